// File: rtl/rk4_axis_stall_detector.sv
// AXI-Stream stall detector feeding the RK4 deadlock monitor.
// Flags channels whose handshake has stalled for STALL_THRESH cycles.
module rk4_axis_stall_detector #(
  parameter  int NUM_CH       = 2,
  parameter  int STALL_THRESH = 16,
  parameter  int CNT_W        = 16,
  localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_dir,
  input  logic              inst_idle,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              stall_any,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_ch,
  output logic [CNT_W-1:0]  event_cnt
);

  localparam int CW = $clog2(STALL_THRESH + 1);
  localparam logic [CW-1:0] LAST = CW'(STALL_THRESH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_BLOCK
  } state_t;

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] nblk;
  logic [NUM_CH-1:0] enter;
  logic [IDX_W-1:0]  first_d;
  logic              any_enter;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t        st_q;
    state_t        st_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // producer stalls on valid&!ready, consumer on ready&!valid
    assign stall[g] = !inst_idle &&
      (ch_dir[g] ? (ch_tvalid[g] && !ch_tready[g])
                 : (ch_tready[g] && !ch_tvalid[g]));

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        S_IDLE: begin
          if (stall[g]) begin
            st_d  = S_COUNT;
            cnt_d = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        S_COUNT: begin
          if (!stall[g]) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end else if (cnt_q == LAST) begin
            st_d = S_BLOCK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BLOCK: begin
          if (!stall[g]) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
      end else if (clear) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign nblk[g]  = (st_d == S_BLOCK);
    assign enter[g] = (st_q != S_BLOCK) && (st_d == S_BLOCK);
  end

  assign any_enter = |enter;

  always_comb begin
    first_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) first_d = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      axis_block_sigs <= '0;
      stall_any       <= 1'b0;
      first_valid     <= 1'b0;
      first_ch        <= '0;
      event_cnt       <= '0;
    end else if (clear) begin
      axis_block_sigs <= '0;
      stall_any       <= 1'b0;
      first_valid     <= 1'b0;
      first_ch        <= '0;
      event_cnt       <= '0;
    end else begin
      axis_block_sigs <= nblk;
      stall_any       <= |nblk;
      if (any_enter && event_cnt != {CNT_W{1'b1}})
        event_cnt <= event_cnt + 1'b1;
      if (any_enter && !first_valid) begin
        first_valid <= 1'b1;
        first_ch    <= first_d;
      end
    end
  end

endmodule
